// File: rtl/fifo_rd_fwft.sv
// First-word-fall-through read stage of the async FIFO (rclk domain): turns
// rempty/rinc pops into a valid/ready stream. Optional RD_STALL_CNT_EN adds stall_cnt.
module fifo_rd_fwft #(
  parameter int DATA_SIZE = 8,
  parameter int OUT_DEPTH = 2
) (
  input  logic                         rclk,
  input  logic                         rrst_n,
  input  logic                         rempty,
  output logic                         rinc,
  input  logic [DATA_SIZE-1:0]         rdata,
  output logic [DATA_SIZE-1:0]         m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(OUT_DEPTH):0]   m_level
`ifdef RD_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = LW + 1;

  logic [DATA_SIZE-1:0] buffer [OUT_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        occupancy;
  logic                 inflight;
  logic                 pop;
  logic [CW-1:0]        credit;

  // Handshake: a word transfers on every rclk edge where m_valid & m_ready are
  // both 1; once m_valid is high, m_data/m_valid hold until that transfer.
  assign pop = m_valid & m_ready;

  // occupancy + inflight never exceeds OUT_DEPTH, so credit cannot underflow.
  assign credit = CW'(OUT_DEPTH) - CW'(occupancy) - CW'(inflight) + CW'(pop);

  // Timing: m_ready -> pop -> credit -> rinc is a combinational path into the
  // read-pointer logic; budget it alongside the rempty -> rinc path.
  assign rinc = rrst_n & ~rempty & (credit != '0);

  assign m_valid = (occupancy != '0);
  assign m_data  = buffer[rd_ptr];
  assign m_level = occupancy;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      inflight  <= 1'b0;
      for (int i = 0; i < OUT_DEPTH; i++) buffer[i] <= '0;
    end else begin
      inflight <= rinc;
      if (inflight) begin
        buffer[wr_ptr] <= rdata;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + LW'(inflight) - LW'(pop);
    end
  end

`ifdef RD_STALL_CNT_EN
  // Counts back-pressure cycles since the last accepted word, saturating.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stall_cnt <= '0;
    end else if (pop && (stall_cnt != '0)) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
